wb_master_arbiter: RTL and testbench
====================================

WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 SHALL have parameter AW, default 10: Wishbone word-address width, matching the ethmac slave wb_adr_i[11:2].
REQ-002 SHALL have parameter DW, default 32: data width.
REQ-003 SHALL have parameter TIMEOUT, default 16: cycles in BUS without ack/err before forced termination; legal range 2..255.
REQ-004 wb_clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-005 wb_rst_i  in  1  reset, synchronous and active-high.
REQ-006 req_valid  in  2  per-requester transfer request; bit 0 = register-config requester, bit 1 = buffer-descriptor requester.
REQ-007 req_ready  out  2  request accepted this cycle; combinational, one-hot or zero.
REQ-008 req_we  in  2  per-requester write enable.
REQ-009 req_adr  in  2*AW  packed addresses; requester i uses bits [i*AW +: AW].
REQ-010 req_sel  in  8  packed byte selects, 4 bits per requester.
REQ-011 req_dat  in  2*DW  packed write data.
REQ-012 rsp_valid  out  2  one-cycle completion pulse to the granted requester.
REQ-013 rsp_err  out  1  completion ended in error or timeout; qualified by rsp_valid.
REQ-014 rsp_dat  out  DW  read data; qualified by rsp_valid.
REQ-015 wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o  out  AW, DW, 4, 1, 1, 1  registered Wishbone master outputs to the ethmac slave.
REQ-016 wb_dat_i, wb_ack_i, wb_err_i  in  DW, 1, 1  Wishbone slave responses.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement the FSM states IDLE, BUS and DONE.
REQ-019 IDLE with any req_valid: grant one requester, assert its req_ready in the same cycle, latch its we/adr/sel/dat, go to BUS.
REQ-020 Arbitration SHALL be round-robin.
- Both requesters valid: grant the one not granted last.
- Only one valid: grant it.
- The last-grant register SHALL reset to 1, so requester 0 wins the first contention.
REQ-021 BUS: wb_cyc_o = wb_stb_o = 1, and the address, data, sel and we outputs SHALL hold the latched values unchanged.
- Cycle timing: the first BUS cycle is the cycle after acceptance.
REQ-022 BUS, wb_ack_i or wb_err_i sampled high:
- Capture wb_dat_i into rsp_dat.
- Set rsp_err = wb_err_i.
- Go to DONE.
- wb_cyc_o and wb_stb_o SHALL be low in DONE.
REQ-023 ack and err high together SHALL be treated as error (rsp_err = 1).
REQ-024 Timeout:
- A BUS cycle counter SHALL clear on entry to BUS.
- When the counter reaches TIMEOUT-1 with neither ack nor err high, go to DONE with rsp_err = 1 and rsp_dat = 0.
REQ-025 DONE SHALL last exactly one cycle:
- rsp_valid[granted] = 1.
- Update the last-grant register.
- Return to IDLE.
REQ-026 req_ready SHALL be 0 in BUS and DONE; req_valid SHALL be ignored outside IDLE.
REQ-027 Back-to-back latency:
- Acceptance at cycle 0.
- Ack sampled at cycle k.
- rsp_valid at cycle k+1.
- Earliest next acceptance at cycle k+2.
REQ-028 For writes, rsp_dat SHALL carry the captured wb_dat_i value; requesters ignore it.
REQ-029 One transfer per grant; no burst, no wb_cti/bte, no pipelined Wishbone.

Reset
REQ-030 wb_rst_i high at a rising edge SHALL force all of the following on that edge, regardless of state:
- state = IDLE and timeout counter = 0.
- last-grant = 1.
- wb_cyc_o, wb_stb_o, wb_we_o = 0; wb_adr_o, wb_dat_o, wb_sel_o = 0.
- rsp_valid = 0, rsp_err = 0, rsp_dat = 0, busy = 0.
REQ-031 Reset during BUS SHALL abort the transfer silently: no rsp_valid pulse is issued for it.
REQ-032 req_ready SHALL be 0 while wb_rst_i is high.

Verification
REQ-033 Single write: req_valid = 01, we = 1, adr = 0x000, dat = 0x0000A423, sel = F, ack on the 2nd BUS cycle -> wb bus carries those values; rsp_valid = 01 one cycle after ack; rsp_err = 0.
REQ-034 Contention: req_valid = 11 held for 4 transfers, ack always on the 1st BUS cycle -> grant order 0, 1, 0, 1; acceptances 3 cycles apart.
REQ-035 Read: requester 1, adr = 0x100, slave returns 0xDEADBEEF with ack -> rsp_valid = 10, rsp_dat = 0xDEADBEEF, rsp_err = 0.
REQ-036 Error: wb_err_i and wb_ack_i both high in the same cycle -> rsp_err = 1; cyc/stb low in the next cycle.
REQ-037 Timeout: TIMEOUT = 16, slave never responds -> cyc/stb high for exactly 16 cycles; then rsp_valid with rsp_err = 1 and rsp_dat = 0.
REQ-038 Reset mid-transfer: wb_rst_i pulsed on the 3rd BUS cycle -> cyc/stb = 0 after that edge; no rsp_valid; the next contention grants requester 0.

Source files
------------

// File: rtl/wb_master_arbiter_if.sv
// Wishbone classic single-master bus between the arbiter and the ethmac slave port.
// Signal names keep the master's _o/_i view so both ends read the same.
interface wb_master_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic          wb_we_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i;
  logic          wb_err_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/wb_master_arbiter.sv
// Two-requester round-robin arbiter driving one Wishbone classic master port,
// one transfer per grant, with a bounded wait for ack/err.
module wb_master_arbiter #(
  parameter int AW      = 10,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_we,
  input  logic [2*AW-1:0]   req_adr,
  input  logic [7:0]        req_sel,
  input  logic [2*DW-1:0]   req_dat,
  output logic [1:0]        rsp_valid,
  output logic              rsp_err,
  output logic [DW-1:0]     rsp_dat,
  output logic              busy,
  wb_master_arbiter_if.master wb
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          gnt_q, gnt_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic [3:0]    sel_q, sel_d;
  logic          rsp_err_q, rsp_err_d;
  logic [DW-1:0] rsp_dat_q, rsp_dat_d;
  logic          pick;

  // Under contention the requester not served last wins; otherwise the lone one.
  assign pick = (&req_valid) ? ~last_q : req_valid[1];

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    rsp_err_d = rsp_err_q;
    rsp_dat_d = rsp_dat_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    case (state_q)
      IDLE: begin
        if ((|req_valid) && !wb_rst_i) begin
          req_ready = pick ? 2'b10 : 2'b01;
          gnt_d     = pick;
          we_d      = req_we[pick];
          adr_d     = pick ? req_adr[2*AW-1:AW] : req_adr[AW-1:0];
          dat_d     = pick ? req_dat[2*DW-1:DW] : req_dat[DW-1:0];
          sel_d     = pick ? req_sel[7:4] : req_sel[3:0];
          cyc_d     = 1'b1;
          cnt_d     = 8'd0;
          state_d   = BUS;
        end
      end
      BUS: begin
        if (wb.wb_ack_i || wb.wb_err_i) begin
          // err wins when both arrive together
          rsp_dat_d = wb.wb_dat_i;
          rsp_err_d = wb.wb_err_i;
          cyc_d     = 1'b0;
          state_d   = DONE;
        end else if (cnt_q == TO_LAST) begin
          rsp_dat_d = '0;
          rsp_err_d = 1'b1;
          cyc_d     = 1'b0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        rsp_valid = gnt_q ? 2'b10 : 2'b01;
        last_d    = gnt_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      cnt_q     <= 8'd0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= 4'd0;
      rsp_err_q <= 1'b0;
      rsp_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      rsp_err_q <= rsp_err_d;
      rsp_dat_q <= rsp_dat_d;
    end
  end

  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_sel_o = sel_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_dat     = rsp_dat_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: write, contention, read, error,
// timeout and reset-abort sequences with hand-computed expectations.
module tb_wb_master_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
  logic [19:0] req_adr;
  logic [7:0]  req_sel;
  logic [63:0] req_dat;
  logic        rsp_err, busy;
  logic [31:0] rsp_dat;
  int          n_assert = 0;
  int          n_fail   = 0;
  int          n;

  wb_master_arbiter_if #(.AW(10), .DW(32)) wb ();

  wb_master_arbiter #(.AW(10), .DW(32), .TIMEOUT(16)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_adr   (req_adr),
    .req_sel   (req_sel),
    .req_dat   (req_dat),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_dat   (rsp_dat),
    .busy      (busy),
    .wb        (wb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b11; req_we = 2'b00; req_adr = '0;
    req_sel = 8'h00; req_dat = '0;
    wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0; wb.wb_dat_i = 32'h0;
    tick(); tick();
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_cyc", wb.wb_cyc_o, 1'b0);
    chk("rst_stb", wb.wb_stb_o, 1'b0);
    chk("rst_we", wb.wb_we_o, 1'b0);
    chk("rst_adr", wb.wb_adr_o, 10'h0);
    chk("rst_dat", wb.wb_dat_o, 32'h0);
    chk("rst_sel", wb.wb_sel_o, 4'h0);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rsp_dat", rsp_dat, 32'h0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0; req_valid = 2'b00;
    tick();

    // Single write from requester 0, ack on the 2nd BUS cycle
    req_valid = 2'b01; req_we = 2'b01; req_adr = {10'h3FF, 10'h000};
    req_sel = 8'h3F; req_dat = {32'h1111_1111, 32'h0000_A423};
    #1 chk("wr_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    #1 chk("wr_bus_ready", req_ready, 2'b00);
    chk("wr_cyc", wb.wb_cyc_o, 1'b1);
    chk("wr_stb", wb.wb_stb_o, 1'b1);
    chk("wr_we", wb.wb_we_o, 1'b1);
    chk("wr_adr", wb.wb_adr_o, 10'h000);
    chk("wr_dat", wb.wb_dat_o, 32'h0000_A423);
    chk("wr_sel", wb.wb_sel_o, 4'hF);
    chk("wr_busy", busy, 1'b1);
    tick();
    chk("wr_bus2_cyc", wb.wb_cyc_o, 1'b1);
    chk("wr_bus2_dat", wb.wb_dat_o, 32'h0000_A423);
    wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'h0000_0055;
    tick(); wb.wb_ack_i = 1'b0;
    chk("wr_rsp_valid", rsp_valid, 2'b01);
    chk("wr_rsp_err", rsp_err, 1'b0);
    chk("wr_rsp_dat", rsp_dat, 32'h0000_0055);
    chk("wr_done_cyc", wb.wb_cyc_o, 1'b0);
    chk("wr_done_stb", wb.wb_stb_o, 1'b0);
    tick();
    chk("wr_idle_rsp", rsp_valid, 2'b00);
    chk("wr_idle_busy", busy, 1'b0);

    // Reset restores last-grant so requester 0 wins first contention
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 2'b11; req_we = 2'b00; req_adr = {10'h008, 10'h004};
    for (int i = 0; i < 4; i++) begin
      #1 chk("cont_ready", req_ready, (i % 2) ? 2'b10 : 2'b01);
      tick();
      wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'(i);
      chk("cont_adr", wb.wb_adr_o, (i % 2) ? 10'h008 : 10'h004);
      tick(); wb.wb_ack_i = 1'b0;
      chk("cont_rsp", rsp_valid, (i % 2) ? 2'b10 : 2'b01);
      chk("cont_done_ready", req_ready, 2'b00);
      if (i == 3) req_valid = 2'b00;
      tick();
    end

    // Read from requester 1
    req_valid = 2'b10; req_we = 2'b00; req_adr = {10'h100, 10'h004};
    #1 chk("rd_ready", req_ready, 2'b10);
    tick(); req_valid = 2'b00;
    chk("rd_adr", wb.wb_adr_o, 10'h100);
    chk("rd_we", wb.wb_we_o, 1'b0);
    wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'hDEAD_BEEF;
    tick(); wb.wb_ack_i = 1'b0;
    chk("rd_rsp_valid", rsp_valid, 2'b10);
    chk("rd_rsp_dat", rsp_dat, 32'hDEAD_BEEF);
    chk("rd_rsp_err", rsp_err, 1'b0);
    tick();

    // ack and err together
    req_valid = 2'b01; req_adr = {10'h100, 10'h010};
    #1 chk("err_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    wb.wb_ack_i = 1'b1; wb.wb_err_i = 1'b1; wb.wb_dat_i = 32'h0000_1234;
    tick(); wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0;
    chk("err_rsp_valid", rsp_valid, 2'b01);
    chk("err_rsp_err", rsp_err, 1'b1);
    chk("err_cyc", wb.wb_cyc_o, 1'b0);
    chk("err_stb", wb.wb_stb_o, 1'b0);
    tick();

    // Silent slave: forced termination after 16 BUS cycles
    req_valid = 2'b01; wb.wb_dat_i = 32'hFFFF_FFFF;
    #1 chk("to_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    n = 0;
    while (wb.wb_cyc_o && n < 40) begin
      n++;
      tick();
    end
    chk("to_cycles", n, 16);
    chk("to_rsp_valid", rsp_valid, 2'b01);
    chk("to_rsp_err", rsp_err, 1'b1);
    chk("to_rsp_dat", rsp_dat, 32'h0);
    tick();

    // Reset on the 3rd BUS cycle aborts silently; last grant was 0 so 1 wins now
    req_valid = 2'b11;
    #1 chk("rstx_ready", req_ready, 2'b10);
    tick(); req_valid = 2'b00;
    chk("rstx_bus1", wb.wb_cyc_o, 1'b1);
    tick();
    tick();
    chk("rstx_bus3", wb.wb_cyc_o, 1'b1);
    rst = 1'b1; req_valid = 2'b11;
    #1 chk("rstx_ready_in_rst", req_ready, 2'b00);
    tick();
    chk("rstx_cyc", wb.wb_cyc_o, 1'b0);
    chk("rstx_stb", wb.wb_stb_o, 1'b0);
    chk("rstx_busy", busy, 1'b0);
    chk("rstx_rsp", rsp_valid, 2'b00);
    chk("rstx_adr", wb.wb_adr_o, 10'h0);
    chk("rstx_ready_held", req_ready, 2'b00);
    rst = 1'b0; req_valid = 2'b00;
    tick();
    chk("rstx_no_rsp", rsp_valid, 2'b00);
    req_valid = 2'b11;
    #1 chk("rstx_next_grant", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    wb.wb_ack_i = 1'b1;
    tick(); wb.wb_ack_i = 1'b0;
    chk("rstx_next_rsp", rsp_valid, 2'b01);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
